// File: rtl/tt_prim_defs.sv
// tt_prim_defs: shared state encoding and constant helpers for the tt_prim mux primitives
package tt_prim_defs;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PARK = 1'b1
    } state_t;

    // Ceiling log2 for elaboration-time width derivation; clog2(1) returns 0
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/tt_prim_mux_tree.sv
// tt_prim_mux_tree: combinational N_IN:1 W-bit selector with safe value for out-of-range index
module tt_prim_mux_tree
    import tt_prim_defs::*;
#(
    parameter int              N_IN     = 4,
    parameter int              W        = 1,
    parameter int              SEL_W    = clog2(N_IN),
    parameter logic [W-1:0]    PARK_VAL = '0
) (
    input  logic [N_IN*W-1:0]  i_data,
    input  logic [SEL_W-1:0]   i_sel,
    output logic [W-1:0]       o_data
);

    // At most one index matches; an unmatched (out-of-range) select leaves PARK_VAL
    always_comb begin
        o_data = PARK_VAL;
        for (int k = 0; k < N_IN; k++)
            if (i_sel == SEL_W'(k)) o_data = i_data[k*W +: W];
    end

endmodule

// File: rtl/tt_prim_mux_seq.sv
// tt_prim_mux_seq: registered N_IN:1 selector that parks on a safe value while switching channels
module tt_prim_mux_seq
    import tt_prim_defs::*;
#(
    parameter int              N_IN        = 4,
    parameter int              W           = 1,
    parameter int              SEL_W       = clog2(N_IN),
    parameter int              PARK_CYCLES = 2,
    parameter logic [W-1:0]    PARK_VAL    = '0,
    parameter int              RST_SEL     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_IN*W-1:0]  in_data,
    input  logic [SEL_W-1:0]   sel_req,
    input  logic               sel_valid,
    output logic               sel_ready,
    output logic [SEL_W-1:0]   sel_cur,
    output logic               busy,
    output logic [W-1:0]       out_data
);

    localparam int CNT_W = clog2(PARK_CYCLES) + 1;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [SEL_W-1:0]   r_pending, w_pending_nxt;
    logic [SEL_W-1:0]   r_sel_cur, w_sel_nxt;
    logic [W-1:0]       w_mux;
    logic [W-1:0]       r_out;

    tt_prim_mux_tree #(
        .N_IN     (N_IN),
        .W        (W),
        .SEL_W    (SEL_W),
        .PARK_VAL (PARK_VAL)
    ) u_tree (
        .i_data (in_data),
        .i_sel  (r_sel_cur),
        .o_data (w_mux)
    );

    // FSM state, park counter, pending and committed select registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_sel_cur <= SEL_W'(RST_SEL);
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_sel_cur <= w_sel_nxt;
        end
    end

    // Accept a differing request into PARK; commit the pending index when the count expires
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending;
        w_sel_nxt     = r_sel_cur;
        if (r_state == ST_IDLE) begin
            if (sel_valid && sel_req != r_sel_cur) begin
                w_pending_nxt = sel_req;
                w_cnt_nxt     = CNT_W'(PARK_CYCLES - 1);
                w_state_nxt   = ST_PARK;
            end
        end else if (r_cnt == '0) begin
            w_sel_nxt   = r_pending;
            w_state_nxt = ST_IDLE;
        end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    // Output register: selected channel while idle, safe value while parking or in reset
    always_ff @(posedge clk) begin
        if (!rst_n) r_out <= PARK_VAL;
        else        r_out <= (r_state == ST_IDLE) ? w_mux : PARK_VAL;
    end

    assign sel_ready = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_PARK);
    assign sel_cur   = r_sel_cur;
    assign out_data  = r_out;

endmodule

// File: tb/tb_tt_prim_mux_seq.sv
// tb_tt_prim_mux_seq: randomized and directed checks of tt_prim_mux_seq against an edge-timeline model
module tb_tt_prim_mux_seq;

    localparam int PA = 2;
    localparam int PB = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a_in;
    logic [1:0]  a_req, a_cur, a_out;
    logic        a_valid, a_ready, a_busy;
    logic [11:0] b_in;
    logic [1:0]  b_req, b_cur;
    logic [3:0]  b_out;
    logic        b_valid, b_ready, b_busy;

    int checks = 0;
    int failures = 0;

    // model: edge index, edge of last accepted switch, committed and pending indices
    int n = 0;
    int acc_a = -100, acc_b = -100;
    int cur_a = 0, cur_b = 0, new_a = 0, new_b = 0;
    logic [1:0] e_out_a, e_cur_a, e_cur_b;
    logic [3:0] e_out_b;
    logic       e_rdy_a, e_rdy_b;

    always #5 clk = ~clk;

    tt_prim_mux_seq #(.N_IN(4), .W(2), .PARK_CYCLES(PA)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in), .sel_req(a_req), .sel_valid(a_valid),
        .sel_ready(a_ready), .sel_cur(a_cur), .busy(a_busy), .out_data(a_out)
    );

    tt_prim_mux_seq #(.N_IN(3), .W(4), .PARK_CYCLES(PB)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in), .sel_req(b_req), .sel_valid(b_valid),
        .sel_ready(b_ready), .sel_cur(b_cur), .busy(b_busy), .out_data(b_out)
    );

    // Park window after an accept at edge t0 covers edges t0+1 .. t0+P; commit lands on edge t0+P
    task automatic tick();
        bit pa, pb;
        pa = (n > acc_a) && (n <= acc_a + PA);
        pb = (n > acc_b) && (n <= acc_b + PB);
        if (!rst_n) begin
            e_out_a = '0; e_out_b = '0;
            cur_a = 0; cur_b = 0; acc_a = -100; acc_b = -100;
        end else begin
            e_out_a = pa ? 2'b00 : a_in[cur_a*2 +: 2];
            e_out_b = (pb || cur_b >= 3) ? 4'h0 : b_in[cur_b*4 +: 4];
            if (!pa && a_valid && int'(a_req) != cur_a) begin acc_a = n; new_a = int'(a_req); end
            if (!pb && b_valid && int'(b_req) != cur_b) begin acc_b = n; new_b = int'(b_req); end
            if (n == acc_a + PA) cur_a = new_a;
            if (n == acc_b + PB) cur_b = new_b;
        end
        e_cur_a = 2'(cur_a);
        e_cur_b = 2'(cur_b);
        @(posedge clk);
        n++;
        #1;
        e_rdy_a = !((n > acc_a) && (n <= acc_a + PA));
        e_rdy_b = !((n > acc_b) && (n <= acc_b + PB));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_req = '0; b_req = '0;
        a_in = 8'b01_11_10_01; b_in = 12'hA53;
        repeat (3) tick();
        checks++; if (a_out !== 2'b00) begin failures++; $display("FAIL reset_out: got=%h exp=00", a_out); end
        checks++; if (a_cur !== 2'd0) begin failures++; $display("FAIL reset_cur: got=%0d exp=0", a_cur); end
        checks++; if (a_ready !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("FAIL reset_hs: ready=%b busy=%b exp=1/0", a_ready, a_busy); end
        checks++; if (b_out !== 4'h0 || b_ready !== 1'b1) begin failures++; $display("FAIL reset_b: out=%h ready=%b exp=0/1", b_out, b_ready); end
        rst_n = 1'b1;
        tick();
        checks++; if (a_out !== 2'b01) begin failures++; $display("FAIL release_out: got=%h exp=01", a_out); end
        checks++; if (b_out !== 4'h3) begin failures++; $display("FAIL release_b: got=%h exp=3", b_out); end
    endtask

    task automatic test_switch();
        logic [1:0] exp_out [4] = '{2'b01, 2'b00, 2'b00, 2'b11};
        a_req = 2'd2; a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            a_valid = 1'b0;
            checks++; if (a_out !== e_out_a || a_out !== exp_out[i]) begin failures++; $display("FAIL switch_out[%0d]: got=%h exp=%h", i, a_out, exp_out[i]); end
            checks++; if (a_cur !== e_cur_a) begin failures++; $display("FAIL switch_cur[%0d]: got=%0d exp=%0d", i, a_cur, e_cur_a); end
            checks++; if (a_ready !== e_rdy_a || a_busy !== !e_rdy_a) begin failures++; $display("FAIL switch_hs[%0d]: ready=%b busy=%b exp_ready=%b", i, a_ready, a_busy, e_rdy_a); end
        end
    endtask

    task automatic test_same_index();
        a_req = 2'd2; a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (a_busy !== 1'b0 || a_out !== 2'b11 || a_out !== e_out_a) begin failures++; $display("FAIL same_idx[%0d]: busy=%b out=%h exp=0/11", i, a_busy, a_out); end
        end
        a_valid = 1'b0;
    endtask

    task automatic test_busy_ignore();
        a_req = 2'd1; a_valid = 1'b1;
        tick();
        a_req = 2'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (a_out !== e_out_a || a_cur !== e_cur_a || a_ready !== e_rdy_a) begin failures++; $display("FAIL busy_ign[%0d]: out=%h cur=%0d ready=%b exp=%h/%0d/%b", i, a_out, a_cur, a_ready, e_out_a, e_cur_a, e_rdy_a); end
        end
        a_valid = 1'b0;
        checks++; if (a_cur !== 2'd3 || a_out !== 2'b01) begin failures++; $display("FAIL busy_final: cur=%0d out=%h exp=3/01", a_cur, a_out); end
    endtask

    task automatic test_reset_mid_park();
        a_req = 2'd0; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        repeat (PA + 1) tick();
        checks++; if (a_cur !== 2'd0 || a_out !== 2'b01) begin failures++; $display("FAIL mid_pre: cur=%0d out=%h exp=0/01", a_cur, a_out); end
        a_req = 2'd2; a_valid = 1'b1;
        tick();
        a_valid = 1'b0; rst_n = 1'b0;
        tick();
        checks++; if (a_cur !== 2'd0 || a_out !== 2'b00 || a_ready !== 1'b1) begin failures++; $display("FAIL mid_rst: cur=%0d out=%h ready=%b exp=0/00/1", a_cur, a_out, a_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (a_out !== 2'b01 || a_cur !== 2'd0 || a_busy !== 1'b0) begin failures++; $display("FAIL mid_post[%0d]: out=%h cur=%0d busy=%b exp=01/0/0", i, a_out, a_cur, a_busy); end
        end
    endtask

    task automatic test_non_pow2();
        b_req = 2'd3; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        for (int i = 0; i < PB + 2; i++) begin
            tick();
            checks++; if (b_out !== e_out_b || b_out !== 4'h0 || b_cur !== e_cur_b || b_ready !== e_rdy_b) begin failures++; $display("FAIL np2_inv[%0d]: out=%h cur=%0d ready=%b exp=0/%0d/%b", i, b_out, b_cur, b_ready, e_cur_b, e_rdy_b); end
        end
        checks++; if (b_cur !== 2'd3) begin failures++; $display("FAIL np2_cur: got=%0d exp=3", b_cur); end
        b_req = 2'd1; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        repeat (PB + 1) tick();
        checks++; if (b_out !== 4'h5 || b_cur !== 2'd1) begin failures++; $display("FAIL np2_valid: out=%h cur=%0d exp=5/1", b_out, b_cur); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n   = ($urandom_range(0, 59) != 0);
            a_in    = 8'($urandom); b_in = 12'($urandom);
            a_req   = 2'($urandom); b_req = 2'($urandom);
            a_valid = ($urandom_range(0, 2) == 0);
            b_valid = ($urandom_range(0, 2) == 0);
            tick();
            checks++; if (a_out !== e_out_a || a_cur !== e_cur_a || a_ready !== e_rdy_a || a_busy !== !e_rdy_a) begin failures++; $display("FAIL rand_a[%0d]: out=%h cur=%0d ready=%b busy=%b exp=%h/%0d/%b", i, a_out, a_cur, a_ready, a_busy, e_out_a, e_cur_a, e_rdy_a); end
            checks++; if (b_out !== e_out_b || b_cur !== e_cur_b || b_ready !== e_rdy_b || b_busy !== !e_rdy_b) begin failures++; $display("FAIL rand_b[%0d]: out=%h cur=%0d ready=%b busy=%b exp=%h/%0d/%b", i, b_out, b_cur, b_ready, b_busy, e_out_b, e_cur_b, e_rdy_b); end
        end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_same_index();
        test_busy_ignore();
        test_reset_mid_park();
        test_non_pow2();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_prim_mux_seq.md
Name: tt_prim_mux_seq

Overview:
- Parametrised N-input, W-bit registered selector primitive.
- Switching between inputs passes through a deterministic "park" phase that drives a fixed safe value, so downstream logic never sees a direct old-to-new transition.
- Select changes use a valid/ready handshake.
- Used wherever a user-project output bus is switched at runtime, for example the mux tree and per-tile output gating.

Parameters:
- N_IN, 4: number of input channels; minimum 2; need not be a power of two.
- W, 1: width in bits of each channel.
- SEL_W, clog2(N_IN): select width; derived, not overridden by users.
- PARK_CYCLES, 2: number of cycles out_data holds PARK_VAL during a switch; minimum 1.
- PARK_VAL, {W{1'b0}}: safe value driven during park and for invalid selects.
- RST_SEL, 0: channel selected after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  N_IN*W  channel i occupies bits [i*W +: W].
- sel_req  in  SEL_W  requested channel index.
- sel_valid  in  1  request strobe.
- sel_ready  out  1  block can accept a request this cycle.
- sel_cur  out  SEL_W  channel currently committed.
- busy  out  1  park phase in progress.
- out_data  out  W  registered selected data.

Behaviour:
- Reset: synchronous, active-low, sampled on clk rising edge. While rst_n=0 at an edge:
  - state<=IDLE, sel_cur<=RST_SEL, out_data<=PARK_VAL, park counter<=0.
  - After reset: sel_ready=1, busy=0.
  - Reset mid-park aborts the switch. The pending index is discarded and sel_cur returns to RST_SEL.
- State register, two states:
  - IDLE: sel_ready=1, busy=0.
  - PARK: sel_ready=0, busy=1.
  - Both outputs decode the state register directly, with no combinational path from inputs.
- Output register, updated every edge:
  - out_data <= in_data[sel_cur] if state==IDLE and sel_cur<N_IN.
  - Otherwise out_data <= PARK_VAL.
  - Data latency is 1 cycle. A change on the selected channel appears on out_data one edge later.
- Accept: the request is accepted at an edge where sel_valid && sel_ready.
  - If sel_req == sel_cur: no-op. Stay IDLE, no park, out_data uninterrupted.
  - If sel_req != sel_cur: pending<=sel_req, cnt<=PARK_CYCLES-1, state<=PARK.
- In PARK, at each edge:
  - If cnt==0: sel_cur<=pending, state<=IDLE.
  - Otherwise cnt<=cnt-1.
- Switch timing, with the accept at edge E0:
  - out_data shows the old channel through edge E0.
  - out_data shows PARK_VAL for exactly PARK_CYCLES cycles, loaded at edges E1..E_PARK_CYCLES.
  - out_data shows the new channel from edge E_(PARK_CYCLES+1).
  - sel_cur updates at edge E_PARK_CYCLES.
  - sel_ready is low from E0 until E_PARK_CYCLES.
- sel_valid while busy: ignored, not queued. The requester must hold sel_valid until it sees sel_ready.
- Out-of-range sel_req (>= N_IN, possible only when N_IN is not a power of two):
  - Accepted and parked normally.
  - sel_cur then holds the invalid index and out_data stays PARK_VAL until a valid select is committed.
- Counter width: clog2(PARK_CYCLES)+1 bits. No wrap is possible because the count only decrements to 0.
- A back-to-back request presented on the same edge that PARK exits is not accepted. sel_ready goes high only after that edge.

Decomposition:
- Shared package/header tt_prim_defs:
  - IDLE/PARK state encoding localparams.
  - a clog2 constant function used for SEL_W and the counter width.
- One natural sub-module: tt_prim_mux_tree.
  - Purely combinational N_IN:1, W-bit selector.
  - Returns PARK_VAL for an out-of-range index.
  - The top instantiates it, followed by the output register and the FSM.

Test Plan:
1. Reset release: N_IN=4, W=2, PARK_CYCLES=2, in_data={3:01, 2:11, 1:10, 0:01}, hold rst_n=0 for 3 cycles -> out_data=00, sel_cur=0, sel_ready=1; first edge after release out_data=01.
2. Normal switch: sel_req=2, sel_valid=1 for one cycle at E0 -> out_data=01 through E0; out_data=00 after E1 and E2; sel_cur=2 at E2; out_data=11 after E3; sel_ready low from E0 until E2.
3. Same-index request: with sel_cur=2, request 2 -> busy never asserts, out_data stays 11 every cycle.
4. Request while busy: after a switch to 1 starts, present sel_req=3 throughout PARK -> ignored; accepted on the first edge with sel_ready=1; final sel_cur=3, out_data=01.
5. Reset mid-park: assert rst_n=0 at E1 of a switch from 0 to 2 -> at the next edge state=IDLE, sel_cur=0, out_data=00; then 01 one edge after release.
6. Non-power-of-two: N_IN=3, W=4, in_data={2:A, 1:5, 0:3}, request sel_req=3 -> after park out_data remains 0; then request 1 -> out_data=5 after PARK_CYCLES+1 edges.
